sram_write_aggregator: RTL and testbench
========================================

SRAM_WRITE_AGGREGATOR -- requirements
Module: sram_write_aggregator

Interface
REQ-001 SHALL have parameters: DATA_W default 16, word width; FETCH_W default 4, words per SRAM line; ADDR_W default 8, line address width.
REQ-002 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-003 SHALL have ports: rst_n  in  1  asynchronous active-low reset.
REQ-004 SHALL have ports: clk_en  in  1  global clock enable; when low, all state is frozen.
REQ-005 SHALL have ports: data_in  in  DATA_W  stream word; data_in_valid  in  1; data_in_ready  out  1.
REQ-006 SHALL have ports: cfg_start_addr  in  ADDR_W  first line address; cfg_extent  in  ADDR_W  lines before wrap, where 0 means 2^ADDR_W.
REQ-007 SHALL have ports: rd_block  in  1  read owns the single SRAM port this cycle.
REQ-008 SHALL have ports: mem_addr_in_bank  out  ADDR_W; mem_cen_in_bank  out  1; mem_wen_in_bank  out  1; mem_data_in_bank  out  FETCH_W x DATA_W. Enables are active-high; the bank inverts them.
REQ-009 SHALL have ports: lines_written  out  16  saturating count of completed line writes.

Function
REQ-010 SHALL accept a word only when data_in_valid && data_in_ready && clk_en.
REQ-011 SHALL place the k-th accepted word of a line (k = 0..FETCH_W-1) in lane k of an aggregation register, with lane 0 in bits [DATA_W-1:0].
REQ-012 SHALL move a full line into a single pending buffer and set pend_valid on the cycle the FETCH_W-th word is accepted, then reset agg_cnt to 0.
REQ-013 SHALL define wr_fire = pend_valid && !rd_block && clk_en, and SHALL drive mem_cen_in_bank = mem_wen_in_bank = wr_fire combinationally.
REQ-014 SHALL drive mem_data_in_bank from the pending buffer, and SHALL drive it to 0 when pend_valid is low.
REQ-015 SHALL drive mem_addr_in_bank = (cfg_start_addr + line_idx) mod 2^ADDR_W.
REQ-016 SHALL keep the latency from acceptance of the last word to wr_fire at exactly 1 cycle when rd_block is low.
REQ-017 SHALL, on wr_fire, clear pend_valid unless a new line completes in the same cycle; in that case pend_valid stays 1 and the pending buffer is reloaded.
REQ-018 SHALL, on wr_fire, set line_idx to 0 when line_idx == cfg_extent-1 (wrap); otherwise line_idx increments.
REQ-019 SHALL define data_in_ready = clk_en && (agg_cnt < FETCH_W-1 || !pend_valid || wr_fire), giving no bubble while writes drain.
REQ-020 SHALL, while rd_block is held, keep the pending line and address stable, accept words until the aggregation register is full, and then deassert ready.
REQ-021 SHALL increment lines_written on each wr_fire and saturate it at 16'hFFFF.
REQ-022 SHALL let cfg_* changes take effect only on the next wrap, or immediately when line_idx == 0 and pend_valid == 0.

Reset
REQ-023 SHALL, when rst_n is low, asynchronously clear agg_cnt, line_idx, pend_valid, the pending buffer, the aggregation register and lines_written.
REQ-024 SHALL hold outputs during reset at: data_in_ready 0, mem_cen/wen 0, mem_data 0, mem_addr cfg_start_addr.
REQ-025 SHALL discard a partial or pending line on reset mid-operation, and SHALL NOT issue a write for it afterwards.

Configuration
REQ-026 SHALL, when macro SRAM_AGG_FLUSH_EN is defined, add port flush  in  1 and port flush_done  out  1.
REQ-027 SHALL, with SRAM_AGG_FLUSH_EN defined, handle flush with agg_cnt > 0 by zero-padding lanes agg_cnt..FETCH_W-1, moving the line to the pending buffer when it is free, and resetting agg_cnt.
REQ-028 SHALL, with SRAM_AGG_FLUSH_EN defined, pulse flush_done for 1 cycle on the wr_fire of the flushed line, or the cycle after flush if nothing is buffered.
REQ-029 SHALL, with SRAM_AGG_FLUSH_EN defined, hold data_in_ready low from flush until flush_done.
REQ-030 SHALL, without SRAM_AGG_FLUSH_EN, have neither flush port, and SHALL hold partial lines indefinitely.

Structure
REQ-031 SHALL place DATA_W, FETCH_W and ADDR_W defaults and a line typedef (FETCH_W x DATA_W) in shared package sram_agg_pkg.
REQ-032 SHALL use one sub-module, sram_addr_gen, for line_idx, wrap and address-add logic; everything else is inline.

Verification
REQ-033 SHALL verify: start=8'h10, extent=2, 12 words 1..12 streamed with rd_block=0 -> writes at 10,11,10 with lanes {1,2,3,4},{5,6,7,8},{9,10,11,12}, each 1 cycle after its 4th word, no ready bubble.
REQ-034 SHALL verify: rd_block=1 for 10 cycles while streaming -> one pending write held at its address, 3 more words accepted, ready low, then the write fires on the first cycle rd_block=0.
REQ-035 SHALL verify: start=8'hFE, extent=0, 4 lines -> addresses FE, FF, 00, 01.
REQ-036 SHALL verify: rst_n low after 6 words with a write pending -> no write issued, and post-reset the first line lands at cfg_start_addr.
REQ-037 SHALL verify: clk_en low for 3 cycles mid-line -> no acceptance, no write, state unchanged; resumes correctly.
REQ-038 SHALL verify, with SRAM_AGG_FLUSH_EN: 2 words then flush -> write {w0,w1,0,0}, with flush_done on that cycle.

Source files
------------

// File: rtl/sram_agg_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : sram_agg_pkg                                                     |
// | Brief   : Shared defaults, line type and helpers for the write aggregator. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package sram_agg_pkg;

    localparam int DATA_W_DEF  = 16;
    localparam int FETCH_W_DEF = 4;
    localparam int ADDR_W_DEF  = 8;

    localparam logic [15:0] c_lines_max = 16'hFFFF;

    // Lane 0 occupies the least-significant DATA_W bits.
    typedef logic [FETCH_W_DEF-1:0][DATA_W_DEF-1:0] line_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == c_lines_max) ? v : v + 16'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sram_addr_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : sram_addr_gen                                                    |
// | Brief   : Line index, wrap and start-address add for the write aggregator. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module sram_addr_gen
    import sram_agg_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clk_en,
    input  logic              advance,
    input  logic              pend_valid,
    input  logic [ADDR_W-1:0] cfg_start_addr,
    input  logic [ADDR_W-1:0] cfg_extent,
    output logic [ADDR_W-1:0] addr
);

    logic [ADDR_W-1:0] r_line_idx;
    logic [ADDR_W-1:0] r_start;
    logic [ADDR_W-1:0] r_extent;
    logic [ADDR_W-1:0] w_start;
    logic [ADDR_W-1:0] w_extent;
    logic              w_idle;
    logic              w_wrap;

    // Live config is used only while nothing is in flight at line 0;
    // otherwise the copy captured at the last wrap stays in force.
    assign w_idle   = (r_line_idx == '0) && !pend_valid;
    assign w_start  = w_idle ? cfg_start_addr : r_start;
    assign w_extent = w_idle ? cfg_extent     : r_extent;
    // Extent 0 gives all-ones here, i.e. a full 2^ADDR_W ring.
    assign w_wrap   = (r_line_idx == (w_extent - ADDR_W'(1)));
    assign addr     = w_start + r_line_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_line_idx <= '0;
            r_start    <= '0;
            r_extent   <= '0;
        end else if (clk_en) begin
            if (advance) begin
                r_line_idx <= w_wrap ? '0 : r_line_idx + ADDR_W'(1);
            end
            if (w_idle || (advance && w_wrap)) begin
                r_start  <= cfg_start_addr;
                r_extent <= cfg_extent;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sram_write_aggregator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : sram_write_aggregator                                            |
// | Brief   : Packs a word stream into SRAM lines; one pending line buffer.    |
// |           Optional flush support under macro SRAM_AGG_FLUSH_EN.            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module sram_write_aggregator
    import sram_agg_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int FETCH_W = FETCH_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           clk_en,
    input  logic [DATA_W-1:0]              data_in,
    input  logic                           data_in_valid,
    output logic                           data_in_ready,
    input  logic [ADDR_W-1:0]              cfg_start_addr,
    input  logic [ADDR_W-1:0]              cfg_extent,
    input  logic                           rd_block,
    output logic [ADDR_W-1:0]              mem_addr_in_bank,
    output logic                           mem_cen_in_bank,
    output logic                           mem_wen_in_bank,
    output logic [FETCH_W-1:0][DATA_W-1:0] mem_data_in_bank,
    output logic [15:0]                    lines_written
`ifdef SRAM_AGG_FLUSH_EN
    ,
    input  logic                           flush,
    output logic                           flush_done
`endif
);

    localparam int              CNT_W  = (FETCH_W > 1) ? $clog2(FETCH_W) : 1;
    localparam logic [CNT_W-1:0] c_last = CNT_W'(FETCH_W - 1);

    logic [CNT_W-1:0]              r_agg_cnt;
    logic [FETCH_W-1:0][DATA_W-1:0] r_agg;
    logic [FETCH_W-1:0][DATA_W-1:0] r_pend_buf;
    logic                          r_pend_valid;
    logic [15:0]                   r_lines_written;

    logic [FETCH_W-1:0][DATA_W-1:0] w_full_line;
    logic [FETCH_W-1:0][DATA_W-1:0] w_pad_line;
    logic [FETCH_W-1:0][DATA_W-1:0] w_load_line;
    logic                          w_wr_fire;
    logic                          w_pend_free;
    logic                          w_accept;
    logic                          w_line_done;
    logic                          w_load;
    logic                          w_flush_load;
    logic                          w_flush_block;

    assign w_wr_fire   = r_pend_valid && !rd_block && clk_en;
    assign w_pend_free = !r_pend_valid || w_wr_fire;

    // Gating with rst_n keeps ready low while reset is held.
    assign data_in_ready = rst_n && clk_en && !w_flush_block
                         && ((r_agg_cnt < c_last) || w_pend_free);
    assign w_accept      = data_in_valid && data_in_ready;
    assign w_line_done   = w_accept && (r_agg_cnt == c_last);
    assign w_load        = w_line_done || w_flush_load;
    assign w_load_line   = w_flush_load ? w_pad_line : w_full_line;

    always_comb begin
        w_full_line            = r_agg;
        w_full_line[r_agg_cnt] = data_in;
        for (int k = 0; k < FETCH_W; k++) begin
            w_pad_line[k] = (CNT_W'(k) < r_agg_cnt) ? r_agg[k] : '0;
        end
    end

    assign mem_cen_in_bank  = w_wr_fire;
    assign mem_wen_in_bank  = w_wr_fire;
    assign mem_data_in_bank = r_pend_valid ? r_pend_buf : '0;
    assign lines_written    = r_lines_written;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_agg_cnt       <= '0;
            r_agg           <= '0;
            r_pend_buf      <= '0;
            r_pend_valid    <= 1'b0;
            r_lines_written <= '0;
        end else if (clk_en) begin
            if (w_accept) begin
                r_agg[r_agg_cnt] <= data_in;
            end
            if (w_load) begin
                r_agg_cnt <= '0;
            end else if (w_accept) begin
                r_agg_cnt <= r_agg_cnt + CNT_W'(1);
            end
            // A line landing in the same cycle as a write keeps the buffer full.
            if (w_load) begin
                r_pend_valid <= 1'b1;
                r_pend_buf   <= w_load_line;
            end else if (w_wr_fire) begin
                r_pend_valid <= 1'b0;
            end
            if (w_wr_fire) begin
                r_lines_written <= sat_inc16(r_lines_written);
            end
        end
    end

`ifdef SRAM_AGG_FLUSH_EN
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PAD   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0] r_fl_state;
    logic [1:0] w_fl_state_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fl_state <= ST_IDLE;
        end else begin
            r_fl_state <= w_fl_state_nxt;
        end
    end

    // PAD waits for the pending buffer; DRAIN waits for the last line's write.
    always_comb begin
        w_fl_state_nxt = r_fl_state;
        w_flush_load   = 1'b0;
        flush_done     = 1'b0;
        case (r_fl_state)
            ST_IDLE: begin
                if (clk_en && flush) begin
                    if (r_agg_cnt != '0) begin
                        if (w_pend_free) begin
                            w_flush_load   = 1'b1;
                            w_fl_state_nxt = ST_DRAIN;
                        end else begin
                            w_fl_state_nxt = ST_PAD;
                        end
                    end else if (r_pend_valid && !w_wr_fire) begin
                        w_fl_state_nxt = ST_DRAIN;
                    end else begin
                        w_fl_state_nxt = ST_DONE;
                    end
                end
            end
            ST_PAD: begin
                if (clk_en && w_pend_free) begin
                    w_flush_load   = 1'b1;
                    w_fl_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_wr_fire) begin
                    flush_done     = 1'b1;
                    w_fl_state_nxt = ST_IDLE;
                end
            end
            ST_DONE: begin
                flush_done = 1'b1;
                if (clk_en) begin
                    w_fl_state_nxt = ST_IDLE;
                end
            end
            default: w_fl_state_nxt = ST_IDLE;
        endcase
    end

    assign w_flush_block = flush || (r_fl_state != ST_IDLE);
`else
    assign w_flush_load  = 1'b0;
    assign w_flush_block = 1'b0;
`endif

    sram_addr_gen #(
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk            (clk),
        .rst_n          (rst_n),
        .clk_en         (clk_en),
        .advance        (w_wr_fire),
        .pend_valid     (r_pend_valid),
        .cfg_start_addr (cfg_start_addr),
        .cfg_extent     (cfg_extent),
        .addr           (mem_addr_in_bank)
    );

endmodule
`default_nettype wire

// File: tb/tb_sram_write_aggregator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_sram_write_aggregator                                         |
// | Brief   : Directed and random checks of sram_write_aggregator vs a model.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_sram_write_aggregator;

    localparam int DW = 16;
    localparam int FW = 4;
    localparam int AW = 8;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   clk_en;
    logic [DW-1:0]          data_in;
    logic                   data_in_valid;
    logic                   data_in_ready;
    logic [AW-1:0]          cfg_start_addr;
    logic [AW-1:0]          cfg_extent;
    logic                   rd_block;
    logic [AW-1:0]          mem_addr_in_bank;
    logic                   mem_cen_in_bank;
    logic                   mem_wen_in_bank;
    logic [FW-1:0][DW-1:0]  mem_data_in_bank;
    logic [15:0]            lines_written;
    logic                   flush;
    logic                   flush_done;

    sram_write_aggregator #(
        .DATA_W  (DW),
        .FETCH_W (FW),
        .ADDR_W  (AW)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .clk_en           (clk_en),
        .data_in          (data_in),
        .data_in_valid    (data_in_valid),
        .data_in_ready    (data_in_ready),
        .cfg_start_addr   (cfg_start_addr),
        .cfg_extent       (cfg_extent),
        .rd_block         (rd_block),
        .mem_addr_in_bank (mem_addr_in_bank),
        .mem_cen_in_bank  (mem_cen_in_bank),
        .mem_wen_in_bank  (mem_wen_in_bank),
        .mem_data_in_bank (mem_data_in_bank),
        .lines_written    (lines_written)
`ifdef SRAM_AGG_FLUSH_EN
        ,
        .flush            (flush),
        .flush_done       (flush_done)
`endif
    );

`ifndef SRAM_AGG_FLUSH_EN
    assign flush_done = 1'b0;
`endif

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model: words accepted but not yet written, plus write count.
    logic [DW-1:0] wq[$];
    int unsigned   m_lines;
    int unsigned   m_start;
    int unsigned   m_ext;
    bit            fl_wait;
    bit            fl_next;

    logic [AW-1:0]     wlog_addr[$];
    logic [FW*DW-1:0]  wlog_data[$];
    int                n_acc;
    int                n_done_w;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [FW*DW-1:0] head_line();
        logic [FW*DW-1:0] v;
        v = '0;
        for (int k = 0; k < FW; k++) v[k*DW +: DW] = wq[k];
        return v;
    endfunction

    // One clock: compare at negedge, advance model at posedge, return at +1.
    task automatic step();
        int          sz;
        logic        exp_fire;
        logic        exp_ready;
        logic        exp_done;
        logic [AW-1:0] exp_addr;
        @(negedge clk);
        sz        = wq.size();
        exp_fire  = rst_n && clk_en && (sz >= FW) && !rd_block;
        exp_ready = rst_n && clk_en && ((sz < 2*FW-1) || exp_fire);
        exp_done  = 1'b0;
`ifdef SRAM_AGG_FLUSH_EN
        exp_ready = exp_ready && !flush && !fl_wait && !fl_next;
        exp_done  = (fl_wait && exp_fire && sz == FW) || fl_next;
        chk("flush_done", flush_done, exp_done);
`endif
        exp_addr = AW'((m_start + (m_lines % m_ext)) % 256);
        chk("ready", data_in_ready, exp_ready);
        chk("cen", mem_cen_in_bank, exp_fire);
        chk("wen", mem_wen_in_bank, exp_fire);
        chk("addr", mem_addr_in_bank, exp_addr);
        chk("data", mem_data_in_bank, (sz >= FW) ? head_line() : '0);
        chk("lines", lines_written, (m_lines > 65535) ? 65535 : m_lines);
        if (mem_cen_in_bank) begin
            wlog_addr.push_back(mem_addr_in_bank);
            wlog_data.push_back(mem_data_in_bank);
        end
        if (mem_cen_in_bank && flush_done) n_done_w++;
        if (data_in_valid && data_in_ready) n_acc++;
        @(posedge clk);
        if (exp_fire) begin
            for (int k = 0; k < FW; k++) void'(wq.pop_front());
            m_lines++;
        end
        if (data_in_valid && exp_ready) wq.push_back(data_in);
`ifdef SRAM_AGG_FLUSH_EN
        if (exp_done) begin
            fl_wait = 1'b0;
            fl_next = 1'b0;
        end else if (rst_n && clk_en && flush && !fl_wait && !fl_next) begin
            if (wq.size() % FW != 0) begin
                while (wq.size() % FW != 0) wq.push_back('0);
                fl_wait = 1'b1;
            end else if (wq.size() >= FW && !exp_fire) begin
                fl_wait = 1'b1;
            end else if (wq.size() >= FW) begin
                fl_wait = 1'b1;
            end else begin
                fl_next = 1'b1;
            end
        end
`endif
        #1;
    endtask

    // Called one time unit after a rising edge.
    task automatic do_async_reset(input logic [AW-1:0] start, input logic [AW-1:0] ext);
        data_in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_ready", data_in_ready, 1'b0);
        chk("rst_cen", mem_cen_in_bank, 1'b0);
        chk("rst_data", mem_data_in_bank, '0);
        chk("rst_lines", lines_written, 16'd0);
        cfg_start_addr = start;
        cfg_extent     = ext;
        m_start        = start;
        m_ext          = (ext == 0) ? 256 : ext;
        m_lines        = 0;
        fl_wait        = 1'b0;
        fl_next        = 1'b0;
        wq.delete();
        #1;
        chk("rst_addr", mem_addr_in_bank, start);
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic send(input logic [DW-1:0] w);
        data_in_valid = 1'b1;
        data_in       = w;
        step();
    endtask

    task automatic idle(input int n);
        data_in_valid = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int acc0;
        logic [FW*DW-1:0] exp_line;
        rst_n = 1'b0; clk_en = 1'b1; data_in = '0; data_in_valid = 1'b0;
        rd_block = 1'b0; flush = 1'b0; n_acc = 0; n_done_w = 0;
        cfg_start_addr = 8'h10; cfg_extent = 8'd2;
        m_start = 'h10; m_ext = 2; m_lines = 0; fl_wait = 0; fl_next = 0;
        @(posedge clk); #1;
        step();
        rst_n = 1'b1;

        // Continuous stream, extent 2 ring at 0x10
        n_acc = 0;
        for (int i = 1; i <= 12; i++) send(DW'(i));
        chk("stream_no_bubble", n_acc, 12);
        idle(2);
        chk("stream_nwr", wlog_addr.size(), 3);
        if (wlog_addr.size() == 3) begin
            chk("stream_a0", wlog_addr[0], 8'h10);
            chk("stream_a1", wlog_addr[1], 8'h11);
            chk("stream_a2", wlog_addr[2], 8'h10);
            chk("stream_d0", wlog_data[0], 64'h0004_0003_0002_0001);
            chk("stream_d2", wlog_data[2], 64'h000C_000B_000A_0009);
        end

        // Read blocks the port for 10 cycles while streaming
        wlog_addr.delete(); wlog_data.delete(); n_acc = 0;
        rd_block = 1'b1;
        for (int i = 0; i < 10; i++) send(DW'($urandom));
        chk("blk_accepted", n_acc, 7);
        chk("blk_nwr", wlog_addr.size(), 0);
        rd_block = 1'b0;
        send(DW'($urandom));
        chk("blk_release_wr", wlog_addr.size(), 1);
        if (wlog_addr.size() == 1) chk("blk_addr", wlog_addr[0], 8'h11);
        idle(3);

        // Full 256-line ring crossing the top of the address space
        do_async_reset(8'hFE, 8'd0);
        wlog_addr.delete(); wlog_data.delete();
        for (int i = 0; i < 16; i++) send(DW'($urandom));
        idle(2);
        chk("ring_nwr", wlog_addr.size(), 4);
        if (wlog_addr.size() == 4) begin
            chk("ring_a0", wlog_addr[0], 8'hFE);
            chk("ring_a1", wlog_addr[1], 8'hFF);
            chk("ring_a2", wlog_addr[2], 8'h00);
            chk("ring_a3", wlog_addr[3], 8'h01);
        end

        // Reset with a line pending and a partial line in the aggregator
        rd_block = 1'b1;
        for (int i = 0; i < 6; i++) send(DW'(16'h0F00 + i));
        do_async_reset(8'h40, 8'd4);
        rd_block = 1'b0;
        wlog_addr.delete(); wlog_data.delete();
        for (int i = 0; i < 4; i++) send(DW'(16'hA000 + i));
        idle(2);
        chk("rst_nwr", wlog_addr.size(), 1);
        if (wlog_addr.size() == 1) begin
            chk("rst_first_addr", wlog_addr[0], 8'h40);
            chk("rst_first_data", wlog_data[0], 64'hA003_A002_A001_A000);
        end

        // Clock enable dropped mid-line
        wlog_addr.delete(); wlog_data.delete();
        send(16'h0111); send(16'h0222);
        acc0 = n_acc;
        clk_en = 1'b0;
        for (int i = 0; i < 3; i++) send(16'hDEAD);
        chk("cen_no_accept", n_acc, acc0);
        clk_en = 1'b1;
        send(16'h0333); send(16'h0444);
        idle(2);
        chk("cen_nwr", wlog_addr.size(), 1);
        if (wlog_addr.size() == 1) chk("cen_data", wlog_data[0], 64'h0444_0333_0222_0111);

`ifdef SRAM_AGG_FLUSH_EN
        // Partial line flushed with zero padding
        wlog_addr.delete(); wlog_data.delete(); n_done_w = 0;
        send(16'hAAAA); send(16'hBBBB);
        data_in_valid = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        idle(3);
        chk("flush_nwr", wlog_addr.size(), 1);
        if (wlog_data.size() == 1) chk("flush_data", wlog_data[0], 64'h0000_0000_BBBB_AAAA);
        chk("flush_done_on_wr", n_done_w, 1);
`endif

        // Randomised traffic against the model
        for (int c = 0; c < 1500; c++) begin
            if (c == 750) do_async_reset(AW'($urandom), AW'($urandom_range(0, 6)));
            data_in_valid = ($urandom_range(0, 99) < 70);
            data_in       = DW'($urandom);
            rd_block      = ($urandom_range(0, 99) < 30);
            clk_en        = ($urandom_range(0, 99) < 90);
`ifdef SRAM_AGG_FLUSH_EN
            flush         = ($urandom_range(0, 99) < 3);
`endif
            step();
        end
        clk_en = 1'b1; rd_block = 1'b0; flush = 1'b0;
        idle(4);
        chk("final_empty_or_partial", (wq.size() < FW), 1'b1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
